// File: rtl/riscv_pmp_arb.sv
// riscv_pmp_arb: shares one PMP checker between instruction fetch and data memory, replaying checks hit by CSR writes
package biu_pkg;
  typedef enum logic [2:0] {BYTE = 3'b000, HWORD = 3'b001, WORD = 3'b010, DWORD = 3'b011, QWORD = 3'b100} biu_size_t;
endpackage

module riscv_pmp_arb
  import biu_pkg::*;
#(
  parameter int PLEN       = 34,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [PLEN-1:0] if_adr,
  input  biu_size_t       if_size,
  output logic            if_gnt,
  output logic            if_rsp_vld,
  output logic            if_rsp_exception,
  input  logic            dm_req,
  input  logic [PLEN-1:0] dm_adr,
  input  biu_size_t       dm_size,
  input  logic            dm_we,
  output logic            dm_gnt,
  output logic            dm_rsp_vld,
  output logic            dm_rsp_exception,
  input  logic            pmp_update,
  output logic            chk_req,
  output logic            chk_instruction,
  output logic [PLEN-1:0] chk_adr,
  output biu_size_t       chk_size,
  output logic            chk_we,
  input  logic            chk_exception
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic          upd_q, allow, if_win, done;
  logic [SW-1:0] starve_cnt;
  // with pmp_update low an occupied check stage always completes, so it never blocks a grant
  always_comb begin
    allow  = ~pmp_update & ~upd_q;
    done   = chk_req & ~pmp_update;
    if_win = if_req & (~dm_req | (starve_cnt == SW'(STARVE_MAX)));
    if_gnt = allow & if_win;
    dm_gnt = allow & dm_req & ~if_win;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q            <= 1'b0;
      starve_cnt       <= '0;
      chk_req          <= 1'b0;
      chk_instruction  <= 1'b0;
      chk_adr          <= '0;
      chk_size         <= BYTE;
      chk_we           <= 1'b0;
      if_rsp_vld       <= 1'b0;
      if_rsp_exception <= 1'b0;
      dm_rsp_vld       <= 1'b0;
      dm_rsp_exception <= 1'b0;
    end else begin
      upd_q <= pmp_update;
      if (allow)
        starve_cnt <= (if_gnt | ~if_req) ? '0 :
                      (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + SW'(1);
      if (if_gnt | dm_gnt) begin
        chk_req         <= 1'b1;
        chk_instruction <= if_gnt;
        chk_adr         <= if_gnt ? if_adr : dm_adr;
        chk_size        <= if_gnt ? if_size : dm_size;
        chk_we          <= dm_gnt & dm_we;
      end else if (done) begin
        chk_req <= 1'b0;
      end
      if_rsp_vld <= done & chk_instruction;
      dm_rsp_vld <= done & ~chk_instruction;
      if (done & chk_instruction) if_rsp_exception <= chk_exception;
      if (done & ~chk_instruction) dm_rsp_exception <= chk_exception;
    end
  end
endmodule
